// File: rtl/image_buffer.sv
// image_buffer: captures one pixel frame, pulses the network start, then serves its reads until done.
// Define IMG_THRESH_EN to store pixels binarised against THRESH instead of raw.
module image_buffer #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_W      = 8,
  parameter int DATA_W     = 32,
  parameter int PIX_SHIFT  = 0,
  parameter int THRESH     = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  input  logic              clear,
  input  logic [15:0]       nn_rd_addr,
  output logic [DATA_W-1:0] nn_rd_data,
  output logic              nn_start,
  input  logic              nn_done,
  output logic              busy,
  output logic [9:0]        wr_count,
  output logic [15:0]       frame_cnt
);

  localparam int          AW         = $clog2(NUM_PIXELS);
  localparam logic [9:0]  LAST_IDX   = 10'(NUM_PIXELS - 1);
  localparam logic [15:0] ADDR_LIMIT = 16'(NUM_PIXELS);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [9:0]          wr_count_q, wr_count_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                nn_start_q, nn_start_d;
  logic                busy_q, busy_d;
  logic                pix_ready_q, pix_ready_d;
  logic                wr_en;
  logic [PIX_W-1:0]    wr_pix;
  logic [DATA_W-1:0]   rd_word;
  logic [PIX_W-1:0]    mem [NUM_PIXELS];

`ifdef IMG_THRESH_EN
  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);
  assign wr_pix = (pix_data >= THRESH_V) ? {PIX_W{1'b1}} : '0;
`else
  assign wr_pix = pix_data;
`endif

  // A clear in the same cycle as an offered pixel wins, so that pixel is never written.
  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    frame_cnt_d = frame_cnt_q;
    wr_en       = 1'b0;
    case (state_q)
      LOAD: begin
        if (clear) begin
          wr_count_d = '0;
        end else if (pix_valid) begin
          wr_en = 1'b1;
          if (wr_count_q == LAST_IDX) begin
            wr_count_d = '0;
            state_d    = FIRE;
          end else begin
            wr_count_d = wr_count_q + 10'd1;
          end
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        if (nn_done) begin
          state_d     = LOAD;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = LOAD;
    endcase
    nn_start_d  = (state_d == FIRE);
    busy_d      = (state_d != LOAD);
    pix_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= LOAD;
      wr_count_q  <= '0;
      frame_cnt_q <= '0;
      nn_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      pix_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      frame_cnt_q <= frame_cnt_d;
      nn_start_q  <= nn_start_d;
      busy_q      <= busy_d;
      pix_ready_q <= pix_ready_d;
    end
  end

  // Pixel storage has no reset so a frame survives a reset of the control logic.
  always_ff @(posedge clk) begin
    if (wr_en && !resetn) begin
      mem[wr_count_q[AW-1:0]] <= wr_pix;
    end
  end

  assign rd_word    = {{(DATA_W-PIX_W){1'b0}}, mem[nn_rd_addr[AW-1:0]]};
  assign nn_rd_data = (nn_rd_addr < ADDR_LIMIT) ? (rd_word << PIX_SHIFT) : '0;

  assign pix_ready = pix_ready_q;
  assign nn_start  = nn_start_q;
  assign busy      = busy_q;
  assign wr_count  = wr_count_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_image_buffer.sv
// Self-checking bench for image_buffer: frame-level reference model plus literal spot checks.
// Honours IMG_THRESH_EN the same way the design does.
module tb_image_buffer;

  localparam int NPIX  = 784;
  localparam int SHIFT = 0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic        clear = 1'b0;
  logic [15:0] nn_rd_addr = '0;
  logic [31:0] nn_rd_data;
  logic        nn_start;
  logic        nn_done = 1'b0;
  logic        busy;
  logic [9:0]  wr_count;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level view of the buffer
  int m_mem [NPIX];
  int m_count;
  bit m_frozen;
  bit m_start;
  int m_frames;

  image_buffer #(.PIX_SHIFT(SHIFT)) dut (
    .clk(clk), .resetn(resetn), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .clear(clear), .nn_rd_addr(nn_rd_addr),
    .nn_rd_data(nn_rd_data), .nn_start(nn_start), .nn_done(nn_done),
    .busy(busy), .wr_count(wr_count), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic int storeVal(input logic [7:0] d);
`ifdef IMG_THRESH_EN
    return (d >= 8'd128) ? 255 : 0;
`else
    return int'(d);
`endif
  endfunction

  function automatic logic [31:0] expRead(input logic [15:0] a);
    if (int'(a) >= NPIX) return 32'd0;
    return 32'(m_mem[a]) << SHIFT;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven here and held across the next rising edge; returns 2ns after it.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c,
                               input logic dn, input logic [15:0] a);
    pix_valid  = v;
    pix_data   = d;
    clear      = c;
    nn_done    = dn;
    nn_rd_addr = a;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutOfRange(input string tag);
    nn_rd_addr = 16'd784;
    #1 checkOutput({tag, "_rd784"}, nn_rd_data, 32'd0);
    nn_rd_addr = 16'hFFFF;
    #1 checkOutput({tag, "_rdFFFF"}, nn_rd_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) m_mem[i] = -1;
  end

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      m_count  = 0;
      m_frozen = 0;
      m_start  = 0;
      m_frames = 0;
    end else if (!m_frozen) begin
      if (clear) begin
        m_count = 0;
      end else if (pix_valid) begin
        m_mem[m_count] = storeVal(pix_data);
        if (m_count == NPIX - 1) begin
          m_count  = 0;
          m_frozen = 1;
          m_start  = 1;
        end else begin
          m_count++;
        end
      end
    end else if (m_start) begin
      m_start = 0;
    end else if (nn_done) begin
      m_frozen = 0;
      m_frames = (m_frames + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    checkOutput("pix_ready", {31'd0, pix_ready}, {31'd0, !m_frozen});
    checkOutput("busy", {31'd0, busy}, {31'd0, m_frozen});
    checkOutput("nn_start", {31'd0, nn_start}, {31'd0, m_start});
    checkOutput("wr_count", {22'd0, wr_count}, 32'(m_count));
    checkOutput("frame_cnt", {16'd0, frame_cnt}, 32'(m_frames));
    if (int'(nn_rd_addr) >= NPIX || m_mem[nn_rd_addr] >= 0)
      checkOutput("nn_rd_data", nn_rd_data, expRead(nn_rd_addr));
  end

  function automatic logic [15:0] randAddr();
    int r = int'($urandom % 10);
    if (r == 0) return 16'(784 + $urandom % 200);
    if (r == 1) return 16'hFFFF;
    return 16'($urandom % NPIX);
  endfunction

  initial begin
    #1 resetn = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    resetn = 1'b0;
    checkOutput("rst_wr_count", {22'd0, wr_count}, 32'd0);
    checkOutput("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_nn_start", {31'd0, nn_start}, 32'd0);
    checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Full frame of back-to-back pixels, value = index[7:0]
    for (int i = 0; i < NPIX; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, randAddr());
      if (i == 0) checkOutput("first_accept_count", {22'd0, wr_count}, 32'd1);
    end
    checkOutput("fire_nn_start", {31'd0, nn_start}, 32'd1);
    checkOutput("fire_busy", {31'd0, busy}, 32'd1);
    checkOutput("fire_pix_ready", {31'd0, pix_ready}, 32'd0);
    checkOutOfRange("fire");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 16'd300);
    checkOutput("wait_nn_start", {31'd0, nn_start}, 32'd0);
`ifdef IMG_THRESH_EN
    checkOutput("rd300", nn_rd_data, 32'd0);
    nn_rd_addr = 16'd783;
    #1 checkOutput("rd783", nn_rd_data, 32'd0);
`else
    checkOutput("rd300", nn_rd_data, 32'd44);
    nn_rd_addr = 16'd783;
    #1 checkOutput("rd783", nn_rd_data, 32'd15);
`endif
    checkOutOfRange("wait");

    // Pixels offered while frozen must be ignored
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, randAddr());
    checkOutput("wait_wr_count", {22'd0, wr_count}, 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 16'd300);
    checkOutput("done_pix_ready", {31'd0, pix_ready}, 32'd1);
    checkOutput("done_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    checkOutOfRange("load");

    // Clear after 100 accepts, then clear racing a pixel
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, randAddr());
    checkOutput("pre_clear_count", {22'd0, wr_count}, 32'd100);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, randAddr());
    checkOutput("clear_count", {22'd0, wr_count}, 32'd0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, randAddr());
    checkOutput("clear_drop_count", {22'd0, wr_count}, 32'd0);
    for (int i = 0; i < NPIX - 1; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, randAddr());
    checkOutput("not_yet_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, randAddr());
    checkOutput("full_frame_start", {31'd0, nn_start}, 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, randAddr());
    checkOutput("done_in_fire_busy", {31'd0, busy}, 32'd1);
    checkOutput("done_in_fire_cnt", {16'd0, frame_cnt}, 32'd1);

    // Reset while waiting for the network, then check the frozen frame survives
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, randAddr());
    for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 8'(i) ^ 8'h5A, 1'b0, 1'b0, randAddr());
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, randAddr());
    resetn = 1'b1;
    #1;
    checkOutput("rstwait_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstwait_start", {31'd0, nn_start}, 32'd0);
    checkOutput("rstwait_frames", {16'd0, frame_cnt}, 32'd0);
    checkOutput("rstwait_ready", {31'd0, pix_ready}, 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 16'd200);
    resetn = 1'b0;
`ifdef IMG_THRESH_EN
    checkOutput("rstwait_rd200", nn_rd_data, 32'd255);
`else
    checkOutput("rstwait_rd200", nn_rd_data, 32'd146);
`endif

    // Threshold boundary pixels
    applyStimulus(1'b1, 8'd127, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b1, 8'd128, 1'b0, 1'b0, 16'd0);
    nn_rd_addr = 16'd0;
`ifdef IMG_THRESH_EN
    #1 checkOutput("thr_127", nn_rd_data, 32'd0);
    nn_rd_addr = 16'd1;
    #1 checkOutput("thr_128", nn_rd_data, 32'd255);
`else
    #1 checkOutput("thr_127", nn_rd_data, 32'd127);
    nn_rd_addr = 16'd1;
    #1 checkOutput("thr_128", nn_rd_data, 32'd128);
`endif

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 300) == 0,
                    ($urandom % 8) == 0, randAddr());
    end

    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
